// File: rtl/clasificador_vc_pkg.sv
// clasificador_vc_pkg: shared constants for the VC0/VC1 classifier
package clasificador_vc_pkg;
    localparam int DATA_WIDTH_DEF = 6;
    localparam int SEL_BIT_DEF    = 4;
    localparam logic [1:0] ST_RESET  = 2'b00;
    localparam logic [1:0] ST_INIT   = 2'b01;
    localparam logic [1:0] ST_IDLE   = 2'b10;
    localparam logic [1:0] ST_ACTIVE = 2'b11;
endpackage

// File: rtl/clasificador_vc_if.sv
// clasificador_vc_if: main FIFO read side plus VC0/VC1 write side of the classifier
interface clasificador_vc_if #(
    parameter int DATA_WIDTH = clasificador_vc_pkg::DATA_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0] main_data;
    logic                  main_empty;
    logic                  VC0_pause;
    logic                  VC1_pause;
    logic                  main_pop;
    logic                  VC0_push;
    logic                  VC1_push;
    logic [DATA_WIDTH-1:0] VC0_data;
    logic [DATA_WIDTH-1:0] VC1_data;
    logic                  idle;
    modport master (
        input  main_data, main_empty, VC0_pause, VC1_pause,
        output main_pop, VC0_push, VC1_push, VC0_data, VC1_data, idle
    );
    modport slave (
        output main_data, main_empty, VC0_pause, VC1_pause,
        input  main_pop, VC0_push, VC1_push, VC0_data, VC1_data, idle
    );
endinterface

// File: rtl/clasificador_vc_pops.sv
// clasificador_vc_pops: pop gating toward the main FIFO and the one-cycle read-latency flag
module clasificador_vc_pops (
    input  logic clk,
    input  logic reset_L,
    input  logic active_i,
    input  logic main_empty_i,
    input  logic vc0_pause_i,
    input  logic vc1_pause_i,
    output logic main_pop_o,
    output logic pop_delay_o
);
    logic pop_delay_q;
    logic pop_delay_d;
    // both pauses gate: the class of the next word is unknown until it is read
    always_comb begin
        main_pop_o  = active_i & ~main_empty_i & ~vc0_pause_i & ~vc1_pause_i;
        pop_delay_d = main_pop_o;
    end
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) pop_delay_q <= 1'b0;
        else          pop_delay_q <= pop_delay_d;
    end
    assign pop_delay_o = pop_delay_q;
endmodule

// File: rtl/clasificador_vc.sv
// clasificador_vc: pops main FIFO words and pushes each into VC0/VC1 by its select bit
// Optional per-VC push counters when CLASIF_CONTADORES_EN is defined.
module clasificador_vc
    import clasificador_vc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SEL_BIT    = SEL_BIT_DEF
) (
    input  logic              clk,
    input  logic              reset_L,
    clasificador_vc_if.master bus
`ifdef CLASIF_CONTADORES_EN
   ,output logic [7:0]        cnt_VC0,
    output logic [7:0]        cnt_VC1
`endif
);
    logic [1:0]            state_q, state_d;
    logic                  vc0_push_q, vc0_push_d;
    logic                  vc1_push_q, vc1_push_d;
    logic [DATA_WIDTH-1:0] vc0_data_q, vc0_data_d;
    logic [DATA_WIDTH-1:0] vc1_data_q, vc1_data_d;
    logic                  main_pop;
    logic                  pop_delay;
    logic                  sel;

    clasificador_vc_pops u_pops (
        .clk          (clk),
        .reset_L      (reset_L),
        .active_i     (state_q == ST_ACTIVE),
        .main_empty_i (bus.main_empty),
        .vc0_pause_i  (bus.VC0_pause),
        .vc1_pause_i  (bus.VC1_pause),
        .main_pop_o   (main_pop),
        .pop_delay_o  (pop_delay)
    );

    assign sel = bus.main_data[SEL_BIT];

    // ACTIVE only falls back to IDLE once nothing is left in the pop->push pipeline
    always_comb begin
        state_d    = (state_q == ST_RESET) ? ST_INIT :
                     (state_q == ST_INIT)  ? ST_IDLE :
                     (state_q == ST_IDLE)  ? (bus.main_empty ? ST_IDLE : ST_ACTIVE) :
                     (bus.main_empty && !pop_delay && !(vc0_push_q || vc1_push_q)) ? ST_IDLE : ST_ACTIVE;
        vc0_push_d = pop_delay & ~sel;
        vc1_push_d = pop_delay & sel;
        vc0_data_d = vc0_push_d ? bus.main_data : '0;
        vc1_data_d = vc1_push_d ? bus.main_data : '0;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= ST_RESET;
            vc0_push_q <= 1'b0;
            vc1_push_q <= 1'b0;
            vc0_data_q <= '0;
            vc1_data_q <= '0;
        end else begin
            state_q    <= state_d;
            vc0_push_q <= vc0_push_d;
            vc1_push_q <= vc1_push_d;
            vc0_data_q <= vc0_data_d;
            vc1_data_q <= vc1_data_d;
        end
    end

    assign bus.main_pop = main_pop;
    assign bus.VC0_push = vc0_push_q;
    assign bus.VC1_push = vc1_push_q;
    assign bus.VC0_data = vc0_data_q;
    assign bus.VC1_data = vc1_data_q;
    assign bus.idle     = (state_q == ST_IDLE);

`ifdef CLASIF_CONTADORES_EN
    logic [7:0] cnt_vc0_q, cnt_vc0_d;
    logic [7:0] cnt_vc1_q, cnt_vc1_d;
    always_comb begin
        cnt_vc0_d = cnt_vc0_q + {7'b0, vc0_push_q};
        cnt_vc1_d = cnt_vc1_q + {7'b0, vc1_push_q};
    end
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_vc0_q <= '0;
            cnt_vc1_q <= '0;
        end else begin
            cnt_vc0_q <= cnt_vc0_d;
            cnt_vc1_q <= cnt_vc1_d;
        end
    end
    assign cnt_VC0 = cnt_vc0_q;
    assign cnt_VC1 = cnt_vc1_q;
`endif
endmodule

// File: tb/tb_clasificador_vc.sv
// tb_clasificador_vc: scoreboard bench with a main FIFO model and two occupancy-tracked VC FIFOs
module tb_clasificador_vc;
    localparam int D = 8;

    typedef struct {
        logic [5:0] w;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic reset_L = 1'b1;
    clasificador_vc_if #(.DATA_WIDTH(6)) bus();
`ifdef CLASIF_CONTADORES_EN
    logic [7:0] cnt_VC0, cnt_VC1;
`endif

    clasificador_vc #(.DATA_WIDTH(6), .SEL_BIT(4)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
`ifdef CLASIF_CONTADORES_EN
       ,.cnt_VC0 (cnt_VC0),
        .cnt_VC1 (cnt_VC1)
`endif
    );

    always #5 clk = ~clk;

    exp_t       sbq[$];
    logic [5:0] mq[$];
    int         pops[$];
    exp_t       mon_e;
    int         n_cmp = 0, n_err = 0, cyc = 0, pushes = 0;
    int         occ0 = 0, occ1 = 0;
    bit         force1 = 0, rnd_pause = 0, rnd_drain = 0, last_pop = 0, last_idle = 0;
    logic [5:0] last_word = '0;
    logic [7:0] m0 = '0, m1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        bus.main_empty = (mq.size() == 0);
        bus.VC0_pause  = (occ0 >= D - 3) || (rnd_pause && $urandom_range(0, 3) == 0);
        bus.VC1_pause  = force1 || (occ1 >= D - 3) || (rnd_pause && $urandom_range(0, 3) == 0);
    endtask

    // one clock: sample at negedge (main FIFO read, VC FIFO fill/drain), drive #1 after posedge
    task automatic step();
        bit popped;
        logic [5:0] w;
        popped = 0;
        w = '0;
        @(negedge clk);
        last_pop  = bus.main_pop;
        last_idle = bus.idle;
        if (bus.main_pop) begin
            chk("pop_gate", int'({bus.main_empty, bus.VC0_pause, bus.VC1_pause}), 0);
            pops.push_back(cyc);
            if (mq.size() > 0) begin
                w = mq.pop_front();
                popped = 1;
                last_word = w;
                sbq.push_back('{w, cyc + 2});
            end
        end
`ifdef CLASIF_CONTADORES_EN
        chk("cnt_vc0", int'(cnt_VC0), int'(m0));
        chk("cnt_vc1", int'(cnt_VC1), int'(m1));
        m0 = m0 + {7'b0, bus.VC0_push};
        m1 = m1 + {7'b0, bus.VC1_push};
`endif
        if (bus.VC0_push) begin
            chk("vc0_room", int'(occ0 <= D - 2), 1);
            occ0++;
        end
        if (bus.VC1_push) begin
            chk("vc1_room", int'(occ1 <= D - 2), 1);
            occ1++;
        end
        if (occ0 > 0 && (!rnd_drain || $urandom_range(0, 1) == 1)) occ0--;
        if (occ1 > 0 && (!rnd_drain || $urandom_range(0, 1) == 1)) occ1--;
        @(posedge clk);
        #1;
        if (popped) bus.main_data = w;
        drive();
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #1;
        chk("rst_pop", int'(bus.main_pop), 0);
        chk("rst_push", int'({bus.VC0_push, bus.VC1_push}), 0);
        chk("rst_data", int'({bus.VC0_data, bus.VC1_data}), 0);
        chk("rst_idle", int'(bus.idle), 0);
        sbq.delete();
        mq.delete();
        occ0 = 0; occ1 = 0; force1 = 0;
        m0 = '0; m1 = '0;
        bus.main_empty = 1'b1;
        bus.VC0_pause  = 1'b0;
        bus.VC1_pause  = 1'b0;
        @(negedge clk);
        reset_L = 1'b1;
        step();
        chk("init_not_idle", int'(last_idle), 0);
        chk("init_no_pop", int'(last_pop), 0);
        step();
        chk("idle_after_init", int'(last_idle), 1);
        chk("idle_no_pop", int'(last_pop), 0);
    endtask

    task automatic wait_idle(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            step();
            if (last_idle && mq.size() == 0 && sbq.size() == 0) break;
        end
        chk(name, int'(last_idle), 1);
        chk({name, "_drained"}, sbq.size(), 0);
    endtask

    // monitor: every push must match the oldest popped word, its VC and its due cycle
    always @(negedge clk) begin
        if (reset_L) begin
            if (bus.VC0_push || bus.VC1_push) begin
                chk("one_hot_push", int'(bus.VC0_push & bus.VC1_push), 0);
                if (sbq.size() == 0) chk("spurious_push", int'(bus.VC0_push | bus.VC1_push), 0);
                else begin
                    mon_e = sbq.pop_front();
                    chk("push_vc", int'(bus.VC1_push), int'(mon_e.w[4]));
                    chk("push_cycle", cyc, mon_e.due);
                    chk("push_data", int'(mon_e.w[4] ? bus.VC1_data : bus.VC0_data), int'(mon_e.w));
                    chk("other_vc_data", int'(mon_e.w[4] ? bus.VC0_data : bus.VC1_data), 0);
                    pushes++;
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                chk("push_due", int'(bus.VC0_push | bus.VC1_push), 1);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        int p, npop;
        bus.main_data  = '0;
        bus.main_empty = 1'b1;
        bus.VC0_pause  = 1'b0;
        bus.VC1_pause  = 1'b0;
        #2;
        do_reset();

        // three words, no pauses
        pops.delete();
        mq = '{6'h05, 6'h15, 6'h07};
        drive();
        wait_idle("basic_idle", 40);
        chk("basic_pop_count", pops.size(), 3);
        if (pops.size() == 3) chk("basic_pop_b2b", pops[2] - pops[0], 2);

        // VC1 pause raised the cycle after 6'h10 is popped
        mq = '{6'h10, 6'h01, 6'h02};
        drive();
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_pop && last_word == 6'h10) break;
        end
        chk("pause_pop_seen", int'(last_word), 6'h10);
        force1 = 1;
        drive();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("pause_hold_pop", int'(last_pop), 0);
        end
        force1 = 0;
        drive();
        step();
        chk("pause_resume_pop", int'(last_pop), 1);
        wait_idle("pause_idle", 40);

        // reset with two words in flight
        mq = '{6'h01, 6'h12, 6'h03, 6'h14};
        drive();
        npop = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_pop) npop++;
            if (npop == 2) break;
        end
        chk("flight_pops", npop, 2);
        chk("flight_push_live", int'(bus.VC0_push), 1);
        p = pushes;
        do_reset();
        for (int i = 0; i < 6; i++) step();
        chk("flight_discarded", pushes - p, 0);

        // 20 random words, random pauses and drains
        rnd_pause = 1;
        rnd_drain = 1;
        p = pushes;
        for (int i = 0; i < 20; i++) mq.push_back(6'($urandom));
        drive();
        wait_idle("rand_idle", 400);
        chk("rand_total", pushes - p, 20);
        rnd_pause = 0;
        rnd_drain = 0;

        // 257 VC0-only words after a fresh reset
        do_reset();
        p = pushes;
        for (int i = 0; i < 257; i++) mq.push_back(6'($urandom) & 6'h2F);
        drive();
        wait_idle("wrap_idle", 700);
        chk("wrap_total", pushes - p, 257);
`ifdef CLASIF_CONTADORES_EN
        chk("wrap_cnt_vc0", int'(cnt_VC0), 1);
        chk("wrap_cnt_vc1", int'(cnt_VC1), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
